// File: rtl/div_sequencer.sv
// ============================================================================
//  Module   : div_sequencer
//  Purpose  : Multi-cycle radix-2 restoring divider with its own sequencing
//             FSM for DIV/DIVU/REM/REMU in the EX stage. Divide-by-zero and
//             signed overflow produce their result in one cycle.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module div_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs1,
  input  logic [WIDTH-1:0] rs2,
  input  logic             kill,
  output logic             stall,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] result
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] c_LAST_ITER = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] c_INT_MIN   = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] c_ALL_ONES  = {WIDTH{1'b1}};

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_dvd;     // dividend shifts out the top, quotient bits enter the bottom
  logic [WIDTH-1:0] r_dsr;
  logic [WIDTH-1:0] r_rem;
  logic [1:0]       r_op;
  logic             r_qneg;
  logic             r_rneg;
  logic [WIDTH-1:0] r_result;
  logic             r_valid;

  logic             w_req;
  logic             w_signed;
  logic             w_div0;
  logic             w_ovf;
  logic             w_fast;
  logic [WIDTH-1:0] w_fast_val;
  logic [WIDTH-1:0] w_abs1;
  logic [WIDTH-1:0] w_abs2;
  logic [WIDTH:0]   w_rem_sh;
  logic             w_ge;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_fix_val;
  logic             w_stall;

  // Request decode, fast-path detection, operand magnitudes and iteration step
  always_comb begin
    w_req      = start & ~kill;
    w_signed   = ~op[0];
    w_div0     = (rs2 == '0);
    w_ovf      = w_signed && (rs1 == c_INT_MIN) && (rs2 == c_ALL_ONES);
    w_fast     = w_div0 | w_ovf;
    // Overflow case: quotient is INT_MIN (== rs1), remainder is 0.
    // Divide-by-zero: quotient all ones, remainder is the dividend.
    if (w_div0) begin
      w_fast_val = op[1] ? rs1 : c_ALL_ONES;
    end else begin
      w_fast_val = op[1] ? '0 : rs1;
    end
    w_abs1     = (w_signed && rs1[WIDTH-1]) ? (~rs1 + 1'b1) : rs1;
    w_abs2     = (w_signed && rs2[WIDTH-1]) ? (~rs2 + 1'b1) : rs2;
    // Partial remainder is kept one bit wider for the compare so a
    // divisor magnitude with its MSB set compares correctly.
    w_rem_sh   = {r_rem, r_dvd[WIDTH-1]};
    w_ge       = (w_rem_sh >= {1'b0, r_dsr});
    w_rem_nxt  = w_ge ? (w_rem_sh[WIDTH-1:0] - r_dsr) : w_rem_sh[WIDTH-1:0];
    if (r_op[1]) begin
      w_fix_val = r_rneg ? (~r_rem + 1'b1) : r_rem;
    end else begin
      w_fix_val = r_qneg ? (~r_dvd + 1'b1) : r_dvd;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and pipeline stall
  always_comb begin
    w_next  = r_state;
    w_stall = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          w_stall = 1'b1;
          w_next  = w_fast ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        w_stall = 1'b1;
        if (kill) begin
          w_next = S_IDLE;
        end else if (r_cnt == c_LAST_ITER) begin
          w_next = S_FIX;
        end
      end
      S_FIX: begin
        w_stall = 1'b1;
        w_next  = kill ? S_IDLE : S_DONE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Datapath: operand latch, shift/subtract iteration, sign fix-up, result
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_dvd    <= '0;
      r_dsr    <= '0;
      r_rem    <= '0;
      r_op     <= '0;
      r_qneg   <= 1'b0;
      r_rneg   <= 1'b0;
      r_result <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_op <= op;
            if (w_fast) begin
              r_result <= w_fast_val;
              r_valid  <= 1'b1;
            end else begin
              r_dvd  <= w_abs1;
              r_dsr  <= w_abs2;
              r_qneg <= w_signed & (rs1[WIDTH-1] ^ rs2[WIDTH-1]);
              r_rneg <= w_signed & rs1[WIDTH-1];
              r_rem  <= '0;
              r_cnt  <= '0;
            end
          end
        end
        S_CALC: begin
          if (!kill) begin
            r_rem <= w_rem_nxt;
            r_dvd <= {r_dvd[WIDTH-2:0], w_ge};
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_FIX: begin
          if (!kill) begin
            r_result <= w_fix_val;
            r_valid  <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign stall  = w_stall;
  assign busy   = (r_state != S_IDLE);
  assign valid  = r_valid;
  assign result = r_result;

endmodule

`default_nettype wire

// File: tb/tb_div_sequencer.sv
// ============================================================================
//  Module   : tb_div_sequencer
//  Purpose  : Directed self-checking bench for div_sequencer.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_div_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        kill;
  logic        stall;
  logic        busy;
  logic        valid;
  logic [31:0] result;

  integer n_chk;
  integer n_err;
  logic [31:0] last_res;

  localparam logic [1:0] c_DIV  = 2'b00;
  localparam logic [1:0] c_DIVU = 2'b01;
  localparam logic [1:0] c_REM  = 2'b10;
  localparam logic [1:0] c_REMU = 2'b11;

  div_sequencer #(.WIDTH(32), .CNT_W(6)) u_dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .rs1    (rs1),
    .rs2    (rs2),
    .kill   (kill),
    .stall  (stall),
    .busy   (busy),
    .valid  (valid),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (got !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Issue one operation at cycle T and follow it to its valid cycle T+lat.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat);
    int bad;
    bad = 0;
    @(posedge clk); #1;
    start = 1'b1; op = o; rs1 = a; rs2 = b; kill = 1'b0;
    @(negedge clk);
    chk({tag, "/stall_T"}, {31'd0, stall}, 32'd1);
    for (int k = 1; k <= lat; k++) begin
      @(posedge clk); #1;
      start = 1'b0; op = ~o; rs1 = $urandom; rs2 = $urandom;
      @(negedge clk);
      if (k < lat) begin
        if (valid !== 1'b0 || stall !== 1'b1 || busy !== 1'b1) bad++;
      end
    end
    chk({tag, "/busy_window"}, bad, 32'd0);
    chk({tag, "/valid"},  {31'd0, valid}, 32'd1);
    chk({tag, "/result"}, result, exp);
    chk({tag, "/stall_done"}, {31'd0, stall}, 32'd0);
    last_res = exp;
    @(posedge clk); #1;
    @(negedge clk);
    chk({tag, "/valid_drop"}, {31'd0, valid}, 32'd0);
  endtask

  initial begin
    int bad;
    n_chk = 0; n_err = 0; last_res = 32'd0;
    rst = 1'b1; start = 1'b0; op = 2'b00; rs1 = '0; rs2 = '0; kill = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset/stall",  {31'd0, stall}, 32'd0);
    chk("reset/busy",   {31'd0, busy},  32'd0);
    chk("reset/valid",  {31'd0, valid}, 32'd0);
    chk("reset/result", result, 32'd0);

    // Normal path, unsigned and signed
    run_op("divu_100_7", c_DIVU, 32'd100, 32'd7, 32'd14, 34);
    run_op("remu_100_7", c_REMU, 32'd100, 32'd7, 32'd2,  34);
    run_op("div_m7_2",   c_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
    run_op("rem_m7_2",   c_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
    run_op("rem_7_m2",   c_REM,  32'd7, 32'hFFFF_FFFE, 32'd1, 34);
    run_op("div_min_2",  c_DIV,  32'h8000_0000, 32'd2, 32'hC000_0000, 34);
    run_op("divu_max_1", c_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 34);
    run_op("div_m7_m2",  c_DIV,  32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3, 34);

    // Kill mid-CALC: back to IDLE next cycle, no valid, result untouched
    bad = 0;
    @(posedge clk); #1;
    start = 1'b1; op = c_DIVU; rs1 = 32'd1000; rs2 = 32'd3;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (c == 1) start = 1'b0;
      if (c == 5) kill = 1'b1;
      if (c == 6) kill = 1'b0;
      @(negedge clk);
      if (c == 6) begin
        chk("kill/busy",  {31'd0, busy},  32'd0);
        chk("kill/stall", {31'd0, stall}, 32'd0);
      end
      if (valid !== 1'b0) bad++;
    end
    chk("kill/no_valid", bad, 32'd0);
    chk("kill/result_held", result, last_res);

    // Reset mid-CALC at T+10
    @(posedge clk); #1;
    start = 1'b1; op = c_DIVU; rs1 = 32'd100; rs2 = 32'd7;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      if (c == 1) start = 1'b0;
      if (c == 10) rst = 1'b1;
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid/busy",   {31'd0, busy},  32'd0);
    chk("rst_mid/stall",  {31'd0, stall}, 32'd0);
    chk("rst_mid/valid",  {31'd0, valid}, 32'd0);
    chk("rst_mid/result", result, 32'd0);
    run_op("after_rst", c_DIVU, 32'd100, 32'd7, 32'd14, 34);

    // Fast paths
    run_op("div_5_0",   c_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    run_op("rem_5_0",   c_REM, 32'd5, 32'd0, 32'd5, 1);
    run_op("div_ovf",   c_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("rem_ovf",   c_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
    run_op("remu_7_0",  c_REMU, 32'd7, 32'd0, 32'd7, 1);

    // Back-to-back with start held across DONE
    bad = 0;
    @(posedge clk); #1;
    start = 1'b1; op = c_DIVU; rs1 = 32'd9; rs2 = 32'd3;
    for (int c = 1; c <= 69; c++) begin
      @(posedge clk); #1;
      if (c == 34) begin op = c_REM; rs1 = 32'd10; rs2 = 32'd4; end
      if (c == 36) start = 1'b0;
      @(negedge clk);
      if (c == 34) begin
        chk("b2b/valid1",  {31'd0, valid}, 32'd1);
        chk("b2b/result1", result, 32'd3);
        chk("b2b/stall1",  {31'd0, stall}, 32'd0);
      end else if (c == 35) begin
        chk("b2b/restart_stall", {31'd0, stall}, 32'd1);
        chk("b2b/restart_busy",  {31'd0, busy},  32'd0);
      end else if (c == 69) begin
        chk("b2b/valid2",  {31'd0, valid}, 32'd1);
        chk("b2b/result2", result, 32'd2);
        chk("b2b/stall2",  {31'd0, stall}, 32'd0);
      end else if (valid !== 1'b0) begin
        bad++;
      end
    end
    chk("b2b/no_extra_valid", bad, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
